// File: rtl/audio_pwm_multi.sv
// Multi-channel audio DAC front end. One frame of CHANNELS unsigned samples is taken per carrier
// period through a one-deep buffer. Each channel drives a registered 1-bit output in
// edge-aligned PWM or first-order sigma-delta (PDM) mode.
module audio_pwm_multi #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      underrun_clr,
  output logic                      underrun,
  output logic [CHANNELS-1:0]       pwm
);

  localparam logic [WIDTH-1:0] cnt_max  = '1;
  localparam logic [WIDTH-1:0] midscale = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]          cnt;
  logic                      pend_full;
  logic [CHANNELS*WIDTH-1:0] pending;
  logic [WIDTH-1:0]          active [CHANNELS];
  logic [WIDTH-1:0]          acc    [CHANNELS];
  logic                      mode_q;
  logic                      boundary;
  logic                      accept;
  logic [WIDTH:0]            sum    [CHANNELS];

  // Period boundary, handshake and per-channel accumulator sums.
  always_comb begin
    boundary = enable && (cnt == cnt_max);
    in_ready = !pend_full;
    accept   = in_valid && !pend_full;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc[i]} + {1'b0, active[i]};
    end
  end

  // Carrier counter; held at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // One-frame input buffer and transfer into the active samples at the boundary.
  // A frame accepted on a boundary cycle stays pending for a full period, since the
  // transfer only looks at the pre-edge pend_full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      pending   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= midscale;
      end
    end else if (boundary && pend_full) begin
      pend_full <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        active[i] <= pending[i*WIDTH +: WIDTH];
      end
    end else if (accept) begin
      pending   <= in_data;
      pend_full <= 1'b1;
    end
  end

  // Sticky underrun flag; a set on the same cycle as a clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (boundary && !pend_full) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  // Output generation, mode latch at the boundary and accumulator clear on a mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm    <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i] <= '0;
      end
    end else if (!enable) begin
      pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (mode_q) begin
          pwm[i] <= sum[i][WIDTH];
          acc[i] <= sum[i][WIDTH-1:0];
        end else begin
          pwm[i] <= (cnt < active[i]);
        end
      end
      if (boundary) begin
        mode_q <= mode;
        // Later assignment overrides the accumulator update above.
        if (mode != mode_q) begin
          for (int i = 0; i < CHANNELS; i++) begin
            acc[i] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_pwm_multi.sv
// Self-checking bench for audio_pwm_multi (CHANNELS=2, WIDTH=8): table of per-period density
// vectors, hand-written corner sequences and a randomized run against a cycle reference model.
module tb_audio_pwm_multi;

  localparam int CH = 2;
  localparam int W  = 8;
  localparam int P  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CH*W-1:0] in_data = '0;
  logic          underrun_clr = 1'b0;
  logic          underrun;
  logic [CH-1:0] pwm;

  int errors = 0;
  int checks = 0;

  // Reference model state (integers, one entry per channel).
  int m_cnt;
  int m_active [CH];
  int m_pending[CH];
  int m_acc    [CH];
  bit m_pfull, m_modeq, m_under;
  bit [CH-1:0] m_pwm;

  typedef struct {
    bit       md;
    bit [7:0] s0;
    bit [7:0] s1;
    int       e0;
    int       e1;
  } vec_t;
  vec_t tbl[6];

  audio_pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .underrun_clr(underrun_clr),
    .underrun(underrun), .pwm(pwm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_pfull = 0; m_modeq = 0; m_under = 0; m_pwm = '0;
    for (int c = 0; c < CH; c++) begin
      m_active[c] = P / 2; m_pending[c] = 0; m_acc[c] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    int nacc[CH];
    bit [CH-1:0] npwm;
    bit bnd, acpt, set_u;
    int s;
    bnd   = enable && (m_cnt == P - 1);
    acpt  = in_valid && !m_pfull;
    set_u = bnd && !m_pfull;
    for (int c = 0; c < CH; c++) begin
      nacc[c] = m_acc[c];
      if (!enable) npwm[c] = 1'b0;
      else if (m_modeq) begin
        s       = m_acc[c] + m_active[c];
        npwm[c] = (s >= P);
        nacc[c] = s % P;
      end else npwm[c] = (m_cnt < m_active[c]);
    end
    if (set_u) m_under = 1;
    else if (underrun_clr) m_under = 0;
    if (bnd) begin
      if (mode != m_modeq) for (int c = 0; c < CH; c++) nacc[c] = 0;
      m_modeq = mode;
      if (m_pfull) begin
        for (int c = 0; c < CH; c++) m_active[c] = m_pending[c];
        m_pfull = 0;
      end
    end
    if (acpt) begin
      for (int c = 0; c < CH; c++) m_pending[c] = int'(in_data[c*W +: W]);
      m_pfull = 1;
    end
    m_cnt = enable ? (m_cnt + 1) % P : 0;
    for (int c = 0; c < CH; c++) m_acc[c] = nacc[c];
    m_pwm = npwm;
  endtask

  // One clock: step the model, then compare the DUT just after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("cyc_pwm", int'(pwm), int'(m_pwm));
    chk("cyc_in_ready", int'(in_ready), int'(!m_pfull));
    chk("cyc_underrun", int'(underrun), int'(m_under));
  endtask

  task automatic send_frame(input logic [CH*W-1:0] d);
    bit a, done;
    done = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      a = !m_pfull;
      cycle();
      if (a) done = 1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_boundary();
    bit b, done;
    done = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      b = enable && (m_cnt == P - 1);
      cycle();
      if (b) done = 1;
    end
    if (!done) chk("boundary_timeout", 0, 1);
  endtask

  // Count ones per channel over one aligned carrier period.
  task automatic count_period(input bit drop_valid, output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int k = 0; k < P; k++) begin
      cycle();
      if (drop_valid && k == 0) in_valid = 1'b0;
      c0 += int'(pwm[0]);
      c1 += int'(pwm[1]);
    end
  endtask

  task automatic run_until_cnt(input int target);
    for (int k = 0; k < 1000 && m_cnt != target; k++) cycle();
    if (m_cnt != target) chk("cnt_timeout", m_cnt, target);
  endtask

  initial begin
    int c0, c1;
    tbl[0] = '{md: 1'b0, s0: 8'hC0, s1: 8'h40, e0: 192, e1: 64};
    tbl[1] = '{md: 1'b0, s0: 8'h00, s1: 8'hFF, e0: 0,   e1: 255};
    tbl[2] = '{md: 1'b1, s0: 8'h01, s1: 8'h80, e0: 1,   e1: 128};
    tbl[3] = '{md: 1'b1, s0: 8'h00, s1: 8'hFF, e0: 0,   e1: 255};
    tbl[4] = '{md: 1'b1, s0: 8'h37, s1: 8'hC8, e0: 55,  e1: 200};
    tbl[5] = '{md: 1'b0, s0: 8'h80, s1: 8'h01, e0: 128, e1: 1};

    // Reset state.
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_pwm", int'(pwm), 0);

    // Enable with no frames: midscale output and underrun at the first boundary.
    enable = 1'b1;
    c0 = 0; c1 = 0;
    for (int k = 0; k < P; k++) begin
      cycle();
      if (k == P - 2) chk("underrun_before_bnd", int'(underrun), 0);
      c0 += int'(pwm[0]);
      c1 += int'(pwm[1]);
    end
    chk("mid_ch0", c0, 128);
    chk("mid_ch1", c1, 128);
    chk("underrun_first_bnd", int'(underrun), 1);

    // Clear, then set and clear colliding on a boundary.
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    chk("underrun_clr", int'(underrun), 0);
    run_until_cnt(P - 1);
    underrun_clr = 1'b1;
    cycle();
    chk("underrun_set_wins", int'(underrun), 1);
    cycle();
    underrun_clr = 1'b0;
    chk("underrun_clr_next", int'(underrun), 0);

    // Table: per-period ones density for each mode/sample pair.
    foreach (tbl[i]) begin
      mode = tbl[i].md;
      send_frame({tbl[i].s1, tbl[i].s0});
      wait_boundary();
      count_period(1'b0, c0, c1);
      chk($sformatf("tbl%0d_ch0", i), c0, tbl[i].e0);
      chk($sformatf("tbl%0d_ch1", i), c1, tbl[i].e1);
    end

    // Back-to-back frames: second stalls until the boundary, both play in order.
    mode = 1'b0;
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    send_frame({8'h20, 8'hA0});
    chk("b2b_full", int'(in_ready), 0);
    in_data  = {8'h10, 8'hF0};
    in_valid = 1'b1;
    cycle();
    chk("b2b_stall", int'(in_ready), 0);
    wait_boundary();
    chk("rdy_after_bnd", int'(in_ready), 1);
    count_period(1'b1, c0, c1);
    chk("b2b_a_ch0", c0, 160);
    chk("b2b_a_ch1", c1, 32);
    chk("b2b_no_underrun", int'(underrun), 0);
    count_period(1'b0, c0, c1);
    chk("b2b_b_ch0", c0, 240);
    chk("b2b_b_ch1", c1, 16);

    // Asynchronous reset mid-period with a pending frame.
    run_until_cnt(50);
    send_frame({8'h55, 8'h66});
    run_until_cnt(100);
    chk("pre_rst_full", int'(in_ready), 0);
    chk("pre_rst_pwm0", int'(pwm[0]), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_pwm", int'(pwm), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_underrun", int'(underrun), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    count_period(1'b0, c0, c1);
    chk("post_rst_ch0", c0, 128);
    chk("post_rst_ch1", c1, 128);

    // PDM midscale after a mode change: accumulator cleared, output alternates 0,1.
    mode = 1'b1;
    send_frame({8'h80, 8'h80});
    wait_boundary();
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("pdm80_alt", int'(pwm[0]), k % 2);
    end

    // Randomized run against the reference model.
    for (int k = 0; k < 3000; k++) begin
      enable       = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 299) == 0) mode = ~mode;
      in_valid     = ($urandom_range(0, 3) == 0);
      in_data      = CH*W'($urandom);
      underrun_clr = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
